// File: rtl/frame_serializer.sv
// Parallel-to-serial async frame generator feeding the TX line mux.
// Frame: start(0), DATA_BITS LSB first, optional even parity, stop(1).
//
// state    | meaning
// ---------+-------------------------------------------
// S_IDLE   | line idle (mux_sel=0), waiting for send
// S_START  | start bit (0) on mux_b
// S_DATA   | data bits, LSB first, from shreg[0]
// S_PARITY | even parity of the captured word
// S_STOP   | stop bit (1); done pulses on exit
module frame_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] din,
    output logic                 mux_sel,
    output logic                 mux_b,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        baud_cnt, baud_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par, par_nxt;
    logic                 sel_nxt, b_nxt, busy_nxt, done_nxt;
    logic                 baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            mux_sel  <= 1'b0;
            mux_b    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            par      <= par_nxt;
            mux_sel  <= sel_nxt;
            mux_b    <= b_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par;
        sel_nxt   = mux_sel;
        b_nxt     = mux_b;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                baud_nxt = '0;
                if (send) begin
                    shreg_nxt = din;
                    par_nxt   = ^din;
                    state_nxt = S_START;
                    sel_nxt   = 1'b1;
                    b_nxt     = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                    b_nxt     = shreg[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_nxt = S_PARITY;
                            b_nxt     = par;
                        end else begin
                            state_nxt = S_STOP;
                            b_nxt     = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_cnt + 1'b1;
                        shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
                        b_nxt     = shreg[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = S_STOP;
                    b_nxt     = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = S_IDLE;
                    sel_nxt   = 1'b0;
                    b_nxt     = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                baud_nxt  = '0;
                sel_nxt   = 1'b0;
                b_nxt     = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: a parity instance driven from a frame
// table plus reset/ignore corner cases, and a no-parity instance for back-to-back.
module tb_frame_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n_p, send_p, rst_n_np, send_np;
    logic [7:0] din_p, din_np;
    logic       sel_p, b_p, busy_p, done_p;
    logic       sel_np, b_np, busy_np, done_np;
    logic       line_p, line_np;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign line_p  = sel_p  ? b_p  : 1'b1;
    assign line_np = sel_np ? b_np : 1'b1;

    frame_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst_n(rst_n_p), .send(send_p), .din(din_p),
        .mux_sel(sel_p), .mux_b(b_p), .busy(busy_p), .done(done_p)
    );

    frame_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0)) dut_np (
        .clk(clk), .rst_n(rst_n_np), .send(send_np), .din(din_np),
        .mux_sel(sel_np), .mux_b(b_np), .busy(busy_np), .done(done_np)
    );

    typedef struct {
        logic [7:0]  din;
        logic [10:0] frame;      // bit i = line level during frame slot i
        int          ignore_at;  // frame cycle for a stray send, -1 for none
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Call at a negedge with the parity DUT idle.
    task automatic run_frame(input logic [7:0] d, input logic [10:0] exp, input int ignore_at);
        din_p  = d;
        send_p = 1'b1;
        @(negedge clk);
        send_p = 1'b0;
        din_p  = ~d;
        for (int k = 0; k < 11 * CPB; k++) begin
            if (k == ignore_at) begin
                send_p = 1'b1;
                din_p  = 8'h3C;
            end else if (k == ignore_at + 1) begin
                send_p = 1'b0;
            end
            check("frame_line", line_p, exp[k / CPB]);
            check("frame_busy", busy_p, 1'b1);
            check("frame_done", done_p, 1'b0);
            @(negedge clk);
        end
        check("end_done", done_p, 1'b1);
        check("end_busy", busy_p, 1'b0);
        check("end_line", line_p, 1'b1);
        @(negedge clk);
        check("post_done", done_p, 1'b0);
        check("post_line", line_p, 1'b1);
    endtask

    initial begin
        logic [9:0] exp_np;

        vecs[0] = '{din: 8'hA5, frame: 11'h54A, ignore_at: -1};
        vecs[1] = '{din: 8'h00, frame: 11'h400, ignore_at: -1};
        vecs[2] = '{din: 8'h80, frame: 11'h700, ignore_at: -1};
        vecs[3] = '{din: 8'h3C, frame: 11'h478, ignore_at: -1};
        vecs[4] = '{din: 8'hFF, frame: 11'h5FE, ignore_at: -1};
        vecs[5] = '{din: 8'hA5, frame: 11'h54A, ignore_at: 10};
        exp_np  = 10'h3FE;

        rst_n_p = 1'b0; rst_n_np = 1'b0;
        send_p  = 1'b1; send_np  = 1'b0;   // send during reset must be dropped
        din_p   = 8'hFF; din_np  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_sel", sel_p, 1'b0);
            check("rst_b", b_p, 1'b1);
            check("rst_busy", busy_p, 1'b0);
            check("rst_done", done_p, 1'b0);
            check("rst_line", line_p, 1'b1);
            check("rst_np_busy", busy_np, 1'b0);
        end
        send_p = 1'b0;
        rst_n_p = 1'b1; rst_n_np = 1'b1;
        @(negedge clk);
        check("idle_busy", busy_p, 1'b0);
        check("idle_line", line_p, 1'b1);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].din, vecs[v].frame, vecs[v].ignore_at);
            for (int i = 0; i < 6; i++) begin
                check("gap_busy", busy_p, 1'b0);
                check("gap_line", line_p, 1'b1);
                @(negedge clk);
            end
        end

        // Abort during data bit 3 (frame slot 4).
        din_p  = 8'hA5;
        send_p = 1'b1;
        @(negedge clk);
        send_p = 1'b0;
        for (int k = 0; k < 18; k++) begin
            check("abort_line", line_p, vecs[0].frame[k / CPB]);
            @(negedge clk);
        end
        rst_n_p = 1'b0;
        @(negedge clk);
        rst_n_p = 1'b1;
        check("abort_line_hi", line_p, 1'b1);
        check("abort_busy", busy_p, 1'b0);
        check("abort_sel", sel_p, 1'b0);
        check("abort_done", done_p, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", done_p, 1'b0);
            check("abort_idle", busy_p, 1'b0);
        end
        run_frame(8'h01, 11'h602, -1);

        // Back-to-back without parity: 40-cycle frames, one-cycle done gap.
        din_np  = 8'hFF;
        send_np = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 10 * CPB; k++) begin
                check("b2b_line", line_np, exp_np[k / CPB]);
                check("b2b_busy", busy_np, 1'b1);
                check("b2b_done", done_np, 1'b0);
                @(negedge clk);
            end
            check("b2b_gap_done", done_np, 1'b1);
            check("b2b_gap_line", line_np, 1'b1);
            check("b2b_gap_busy", busy_np, 1'b0);
            if (f == 2) send_np = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("b2b_stop_busy", busy_np, 1'b0);
            check("b2b_stop_line", line_np, 1'b1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
